// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instruction_fetch_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;

  // Canonical RISC-V NOP (addi x0, x0, 0) shown to decode when nothing is fetched
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A redirect target is only legal when it is word aligned
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instruction_fetch
// Brief  : Fetch stage owning the PC. Issues one word request at a time to
//          instruction memory, captures the response into the instruction
//          register and holds it until decode acknowledges. Handles branch /
//          jump redirects, dropping any response already in flight.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          MAX_OUTST = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        fetch_fault
);

  // The flush bookkeeping below only tracks a single in-flight request
  if (MAX_OUTST != 1) begin : g_bad_outst
    $error("instruction_fetch supports exactly one outstanding request");
  end

  fetch_state_t state;
  fetch_state_t next_state;

  logic        flush;
  logic        misaligned_load;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        instr_valid_d;
  logic        flush_d;
  logic        fetch_fault_d;

  // A misaligned redirect is honoured everywhere except once already faulted
  assign misaligned_load = pc_load && is_misaligned(pc_target[1:0]) && (state != S_FAULT);

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    if (misaligned_load) begin
      next_state = S_FAULT;
    end else begin
      case (state)
        S_IDLE: next_state = S_REQ;
        S_REQ: begin
          if (imem_req_ready) next_state = S_WAIT;
        end
        S_WAIT: begin
          if (pc_load) begin
            // Redirect coinciding with the response: drop it and refetch now
            if (imem_rsp_valid) next_state = S_REQ;
          end else if (imem_rsp_valid) begin
            next_state = flush ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: begin
          if (pc_load || instr_ack) next_state = S_REQ;
        end
        S_FAULT: next_state = S_FAULT;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Next values for the registered datapath outputs
  always_comb begin
    pc_d          = pc;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    flush_d       = flush;
    fetch_fault_d = fetch_fault;

    if (pc_load && (state != S_FAULT)) begin
      pc_d = pc_target;
    end

    if (misaligned_load) begin
      // Faulting target stays in pc so the trap handler can report it
      fetch_fault_d = 1'b1;
      instr_valid_d = 1'b0;
      flush_d       = 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // Memory accepted the old address while we redirect: discard its answer
          if (pc_load && imem_req_ready) flush_d = 1'b1;
        end
        S_WAIT: begin
          if (pc_load) begin
            flush_d = !imem_rsp_valid;
          end else if (imem_rsp_valid) begin
            if (flush) begin
              flush_d = 1'b0;
            end else begin
              instr_d       = imem_rsp_data;
              instr_valid_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Redirect wins over a simultaneous acknowledge
          if (pc_load) begin
            instr_valid_d = 1'b0;
          end else if (instr_ack) begin
            pc_d          = pc_plus4;
            instr_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      flush          <= 1'b0;
      fetch_fault    <= 1'b0;
      imem_req_valid <= 1'b0;
    end else begin
      pc             <= pc_d;
      instr          <= instr_d;
      instr_valid    <= instr_valid_d;
      flush          <= flush_d;
      fetch_fault    <= fetch_fault_d;
      imem_req_valid <= (next_state == S_REQ);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_instruction_fetch
// Brief  : Directed self-checking bench for instruction_fetch.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D0  = 32'h0010_0093;
  localparam logic [31:0] D1  = 32'h0020_0113;
  localparam logic [31:0] D2  = 32'h0030_8193;
  localparam logic [31:0] D3  = 32'h0040_0213;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        fetch_fault;

  int total = 0;
  int fails = 0;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pc_load        (pc_load),
    .pc_target      (pc_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered in REQ at address a with ready high; leaves in HOLD with d latched
  task automatic fetch_word(input logic [31:0] a, input logic [31:0] d);
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_addr, a);
    tick();
    check("wait_no_req", 32'(imem_req_valid), 32'd0);
    check("wait_no_valid", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick();
    imem_rsp_valid = 1'b0;
    check("instr", instr, d);
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("pc_of_instr", pc, a);
  endtask

  task automatic ack_word();
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0; instr_ack = 1'b0; pc_load = 1'b0; pc_target = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // Sequential fetch 0x0, 0x4, 0x8 with ack on each word
    reset = 1'b0; imem_req_ready = 1'b1;
    tick();
    fetch_word(32'h0, D0);
    ack_word();
    fetch_word(32'h4, D1);
    ack_word();
    fetch_word(32'h8, D2);
    check("pc_plus4", pc_plus4, 32'hC);

    // Hold without ack: everything stable, no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_instr", instr, D2);
      check("hold_pc", pc, 32'h8);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_req", 32'(imem_req_valid), 32'd0);
    end

    // Redirect beats simultaneous ack in HOLD
    pc_load = 1'b1; pc_target = 32'h40; instr_ack = 1'b1;
    tick();
    pc_load = 1'b0; instr_ack = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_req", 32'(imem_req_valid), 32'd1);
    check("redir_addr", imem_addr, 32'h40);

    // Redirect in WAIT: in-flight response is discarded
    tick();
    check("w_req_low", 32'(imem_req_valid), 32'd0);
    pc_load = 1'b1; pc_target = 32'h100;
    tick();
    pc_load = 1'b0;
    check("w_pc", pc, 32'h100);
    check("w_valid", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = JUNK;
    tick();
    imem_rsp_valid = 1'b0;
    check("drop_valid", 32'(instr_valid), 32'd0);
    check("drop_instr", instr, D2);
    check("drop_req", 32'(imem_req_valid), 32'd1);
    fetch_word(32'h100, D3);
    ack_word();
    check("ack_addr", imem_addr, 32'h104);

    // Redirect in REQ while not ready, to the top word: pc_plus4 wraps
    imem_req_ready = 1'b0; pc_load = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0;
    check("req_redir_addr", imem_addr, 32'hFFFF_FFFC);
    check("req_redir_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_plus4", pc_plus4, 32'h0);

    // Reset in WAIT, then ready low for 3 cycles after release
    imem_req_ready = 1'b1;
    tick();
    check("pre_rst_wait", 32'(imem_req_valid), 32'd0);
    reset = 1'b1; imem_req_ready = 1'b0;
    tick();
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_req", 32'(imem_req_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    fetch_word(32'h0, D0);

    // Misaligned redirect from HOLD: sticky fault, no more requests
    pc_load = 1'b1; pc_target = 32'h102;
    tick();
    pc_load = 1'b0;
    check("flt_fault", 32'(fetch_fault), 32'd1);
    check("flt_pc", pc, 32'h102);
    check("flt_valid", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = JUNK; instr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flt_sticky", 32'(fetch_fault), 32'd1);
      check("flt_no_req", 32'(imem_req_valid), 32'd0);
      check("flt_no_valid", 32'(instr_valid), 32'd0);
      check("flt_pc_keep", pc, 32'h102);
    end
    imem_rsp_valid = 1'b0; instr_ack = 1'b0;

    // Only reset clears the fault
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("clr_fault", 32'(fetch_fault), 32'd0);
    check("clr_pc", pc, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
`default_nettype wire
